sdram_dl_writer: RTL and testbench



---
 rtl/sdram_dl_writer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_sdram_dl_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dl_writer.sv
// rtl/sdram_dl_writer.sv - packs ioctl download bytes into 16-bit SDRAM writes over a req/ack toggle port
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   ioctl_download      download window from the HPS
//   ioctl_wr            one-cycle byte strobe
//   ioctl_addr[24:0]    byte address (bit 0 = lane, [23:1] = word, bit 24 unused)
//   ioctl_dout[7:0]     byte data
//   ioctl_wait          back-pressure, high while the word FIFO is nearly full
//   port_req/port_ack   toggle handshake with the SDRAM controller request port
//   port_we             always 1 (write-only client)
//   port_a[22:0]        word address (offset by BASE_WORD)
//   port_ds[1:0]        byte enables, bit1 = d[15:8], bit0 = d[7:0]
//   port_d[15:0]        write data, even byte in the upper lane
//   busy                data held, queued or in flight
//   done                one-cycle pulse once a finished download is fully written

module sdram_dl_writer #(
    parameter int unsigned BASE_WORD    = 0,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HOLD_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port_req,
    input  logic        port_ack,
    output logic        port_we,
    output logic [22:0] port_a,
    output logic [1:0]  port_ds,
    output logic [15:0] port_d,
    output logic        busy,
    output logic        done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    localparam logic [22:0]   BASE_A    = BASE_WORD[22:0];
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_LVL  = CW'(FIFO_DEPTH - 1);
    localparam logic [IW-1:0] TIMEOUT_C = IW'(HOLD_TIMEOUT);

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ds;
    } entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Hold register: the partially assembled word
    logic          hv_q, hv_d;
    logic [22:0]   ha_q, ha_d;
    logic [15:0]   hd_q, hd_d;
    logic [1:0]    hds_q, hds_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          dl_q, dl_d;

    // Word FIFO
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wait_q, wait_d;

    // Issue side
    state_t        state_q, state_d;
    logic          port_req_q, port_req_d;
    logic [22:0]   port_a_q, port_a_d;
    logic [15:0]   port_d_q, port_d_d;
    logic [1:0]    port_ds_q, port_ds_d;

    // Status
    logic          armed_q, armed_d;
    logic          done_q, done_d;

    // Intermediate combinational signals
    logic          wr_ok;
    logic [1:0]    wr_lane;
    logic [22:0]   wr_word;
    logic [15:0]   merged_d;
    logic [1:0]    merged_ds;
    logic          push;
    entry_t        push_entry;
    logic          pop;
    logic          fifo_room;
    logic          fifo_push;
    logic          fall;
    logic          busy_c;
    logic          addr_unused;

    assign addr_unused = ioctl_addr[24];

    // A slot frees up in the same cycle when the issue side pops.
    assign fifo_room = (count_q != DEPTH_C) || pop;
    assign fifo_push = push && fifo_room;
    assign fall      = dl_q && !ioctl_download;

    // Hold register update and push generation (at most one push per cycle)
    always_comb begin
        hv_d      = hv_q;
        ha_d      = ha_q;
        hd_d      = hd_q;
        hds_d     = hds_q;
        push      = 1'b0;
        wr_ok     = ioctl_wr && ioctl_download;
        wr_lane   = ioctl_addr[0] ? 2'b01 : 2'b10;
        wr_word   = ioctl_addr[23:1];
        merged_ds = hds_q | wr_lane;
        merged_d  = hd_q;
        if (ioctl_addr[0]) begin
            merged_d[7:0] = ioctl_dout;
        end else begin
            merged_d[15:8] = ioctl_dout;
        end
        push_entry.a  = ha_q + BASE_A;
        push_entry.d  = hd_q;
        push_entry.ds = hds_q;

        if (wr_ok) begin
            if (hv_q && (ha_q == wr_word) && ((hds_q & wr_lane) == 2'b00)) begin
                if (merged_ds == 2'b11) begin
                    push          = 1'b1;
                    push_entry.d  = merged_d;
                    push_entry.ds = 2'b11;
                    hv_d          = 1'b0;
                    hd_d          = merged_d;
                    hds_d         = 2'b11;
                end else begin
                    hd_d  = merged_d;
                    hds_d = merged_ds;
                end
            end else begin
                // Different word or a lane written twice: retire the old hold first.
                push  = hv_q;
                hv_d  = 1'b1;
                ha_d  = wr_word;
                hd_d  = ioctl_addr[0] ? {8'h00, ioctl_dout} : {ioctl_dout, 8'h00};
                hds_d = wr_lane;
            end
        end else if (hv_q && (!ioctl_download || (idle_q == TIMEOUT_C)) && fifo_room) begin
            // Flush is deferred (not dropped) while the FIFO has no room.
            push = 1'b1;
            hv_d = 1'b0;
        end

        if (ioctl_wr) begin
            idle_d = '0;
        end else if (idle_q == TIMEOUT_C) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        dl_d = ioctl_download;
    end

    // Issue FSM: one outstanding toggle request at a time
    always_comb begin
        state_d    = state_q;
        port_req_d = port_req_q;
        port_a_d   = port_a_q;
        port_d_d   = port_d_q;
        port_ds_d  = port_ds_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // reset gating keeps a reset cycle from launching a toggle
                if ((count_q != '0) && (port_req_q == port_ack) && !reset) begin
                    pop        = 1'b1;
                    port_a_d   = mem_q[rd_ptr_q].a;
                    port_d_d   = mem_q[rd_ptr_q].d;
                    port_ds_d  = mem_q[rd_ptr_q].ds;
                    port_req_d = ~port_req_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port_ack == port_req_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({fifo_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wait_d = (count_d >= WAIT_LVL);
    end

    // Status: done fires from registered busy, so it lands a cycle after things go quiet.
    always_comb begin
        busy_c  = hv_q || (count_q != '0) || (port_req_q != port_ack);
        done_d  = armed_q && !busy_c;
        armed_d = fall || (armed_q && !done_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hv_q     <= 1'b0;
            ha_q     <= '0;
            hd_q     <= '0;
            hds_q    <= '0;
            idle_q   <= '0;
            dl_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= 1'b0;
            armed_q  <= 1'b0;
            done_q   <= 1'b0;
            // An in-flight request must run to completion with stable outputs.
            if (port_req_q != port_ack) begin
                state_q <= S_WAIT;
            end else begin
                state_q   <= S_IDLE;
                port_a_q  <= '0;
                port_d_q  <= '0;
                port_ds_q <= '0;
            end
        end else begin
            hv_q      <= hv_d;
            ha_q      <= ha_d;
            hd_q      <= hd_d;
            hds_q     <= hds_d;
            idle_q    <= idle_d;
            dl_q      <= dl_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            armed_q   <= armed_d;
            done_q    <= done_d;
            state_q   <= state_d;
            port_a_q  <= port_a_d;
            port_d_q  <= port_d_d;
            port_ds_q <= port_ds_d;
        end
    end

    // Toggle is never reset so a reset cannot fabricate or retract a request.
    always_ff @(posedge clk) begin
        port_req_q <= port_req_d;
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ioctl_wait = wait_q;
    assign port_req   = port_req_q;
    assign port_we    = 1'b1;
    assign port_a     = port_a_q;
    assign port_d     = port_d_q;
    assign port_ds    = port_ds_q;
    assign busy       = busy_c;
    assign done       = done_q;

endmodule

// File: tb/tb_sdram_dl_writer.sv
// tb/tb_sdram_dl_writer.sv - self-checking bench for sdram_dl_writer

module tb_sdram_dl_writer;

    localparam int unsigned BASE = 32'h0010_0000;
    localparam int          TO   = 63;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port_req;
    logic        port_ack;
    logic        port_we;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sdram_dl_writer #(
        .BASE_WORD   (BASE),
        .FIFO_DEPTH  (4),
        .HOLD_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .port_req      (port_req),
        .port_ack      (port_ack),
        .port_we       (port_we),
        .port_a        (port_a),
        .port_ds       (port_ds),
        .port_d        (port_d),
        .busy          (busy),
        .done          (done)
    );

    int checks   = 0;
    int failures = 0;

    // entries are {a[22:0], d[15:0], ds[1:0]}
    logic [40:0] exp_q[$];
    logic [40:0] got_q[$];
    time         tog_t[$];
    int          cmp_idx = 0;

    int stab_err      = 0;
    int done_cnt      = 0;
    int done_busy_err = 0;
    int ack_lat       = 2;
    int hold_cycles   = 0;
    bit saw_wait      = 0;
    int wait_depth    = -1;

    // reference model hold
    bit          m_hv  = 0;
    logic [22:0] m_ha  = '0;
    logic [15:0] m_hd  = '0;
    logic [1:0]  m_hds = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] norm(input logic [40:0] e);
        logic [15:0] m;
        m = {{8{e[1]}}, {8{e[0]}}};
        return {e[40:18], e[17:2] & m, e[1:0]};
    endfunction

    task automatic model_push();
        logic [22:0] a;
        a = m_ha + 23'(BASE);
        exp_q.push_back({a, m_hd, m_hds});
        m_hv = 0;
    endtask

    task automatic model_wr(input logic [24:0] addr, input logic [7:0] b);
        logic [22:0] wa;
        logic [1:0]  ln;
        wa = addr[23:1];
        ln = addr[0] ? 2'b01 : 2'b10;
        if (m_hv && m_ha == wa && (m_hds & ln) == 2'b00) begin
            m_hds = m_hds | ln;
            if (addr[0]) m_hd[7:0] = b; else m_hd[15:8] = b;
            if (m_hds == 2'b11) model_push();
        end else begin
            if (m_hv) model_push();
            m_hv  = 1;
            m_ha  = wa;
            m_hds = ln;
            m_hd  = addr[0] ? {8'h00, b} : {b, 8'h00};
        end
    endtask

    task automatic model_flush();
        if (m_hv) model_push();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] b, output time t_edge);
        int guard;
        guard = 0;
        while (ioctl_wait === 1'b1 && guard < 500) begin
            if (!saw_wait) begin
                saw_wait   = 1;
                wait_depth = exp_q.size() - got_q.size();
            end
            tick();
            guard++;
        end
        if (guard >= 500) check("wait_bound", ioctl_wait, 1'b0);
        ioctl_addr = addr;
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        model_wr(addr, b);
        @(posedge clk);
        t_edge = $time;
        #2;
        ioctl_wr = 1'b0;
    endtask

    task automatic compare_entries(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = cmp_idx; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), norm(got_q[i]), norm(exp_q[i]));
        end
        cmp_idx = exp_q.size();
    endtask

    task automatic end_dl(input string tag);
        int d0;
        int guard;
        ioctl_download = 1'b0;
        model_flush();
        d0    = done_cnt;
        guard = 0;
        while ((got_q.size() < exp_q.size() || done_cnt == d0) && guard < 800) begin
            tick();
            guard++;
        end
        repeat (5) tick();
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_busy_idle"}, busy, 1'b0);
        compare_entries(tag);
        ioctl_download = 1'b1;
        tick();
    endtask

    // controller stand-in: captures requests, checks stability, answers with ack
    initial begin : ctrl
        logic        prev_req;
        logic [40:0] cur;
        int          pend;
        port_ack = 1'b0;
        prev_req = 1'b0;
        cur      = '0;
        pend     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (port_req !== prev_req) begin
                cur = {port_a, port_d, port_ds};
                got_q.push_back(cur);
                tog_t.push_back($time - 1);
                prev_req = port_req;
                pend     = 0;
            end else if (port_req !== port_ack && {port_a, port_d, port_ds} !== cur) begin
                stab_err++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) done_busy_err++;
            end
            if (hold_cycles > 0) begin
                hold_cycles--;
            end else if (port_req !== port_ack) begin
                pend++;
                if (pend >= ack_lat) begin
                    port_ack = port_req;
                    pend     = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        time t, t2;
        int  n0, guard, d0;
        logic [22:0] w;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_port_a", port_a, 23'h0);
        check("rst_port_d", port_d, 16'h0);
        check("rst_port_ds", port_ds, 2'b00);
        check("rst_wait", ioctl_wait, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", port_we, 1'b1);
        check("rst_busy", busy, 1'b0);

        ioctl_download = 1'b1;
        tick();

        // two bytes forming one full word
        n0 = tog_t.size();
        send_byte(25'h000, 8'hAA, t);
        send_byte(25'h001, 8'h55, t2);
        guard = 0;
        while (tog_t.size() == n0 && guard < 20) begin tick(); guard++; end
        check("t1_req_seen", tog_t.size() > n0, 1'b1);
        if (tog_t.size() > n0) begin
            check("t1_toggle_time", tog_t[n0] - t2, 10);
            check("t1_port_a", got_q[n0][40:18], 23'h100000);
            check("t1_port_d", got_q[n0][17:2], 16'hAA55);
            check("t1_port_ds", got_q[n0][1:0], 2'b11);
        end
        end_dl("t1");

        // same lane twice
        send_byte(25'h002, 8'h01, t);
        send_byte(25'h002, 8'h02, t);
        end_dl("t3");

        // partial word flushed by the idle timeout
        n0 = tog_t.size();
        send_byte(25'h005, 8'h12, t);
        repeat (58) tick();
        check("t2_no_early_flush", tog_t.size(), n0);
        model_flush();
        guard = 0;
        while (tog_t.size() == n0 && guard < 40) begin tick(); guard++; end
        check("t2_flushed", tog_t.size() > n0, 1'b1);
        if (tog_t.size() > n0)
            check("t2_flush_window", (tog_t[n0] - t >= TO * 10) && (tog_t[n0] - t <= (TO + 3) * 10), 1'b1);
        end_dl("t2");

        // odd-lane byte held when the download ends
        send_byte(25'h011, 8'h77, t);
        end_dl("t5");
        check("done_busy_zero", done_busy_err, 0);

        // ack withheld during a burst
        hold_cycles = 40;
        saw_wait    = 0;
        for (int i = 0; i < 16; i++) send_byte(25'h040 + 25'(i), 8'($urandom), t);
        check("t4_wait_seen", saw_wait, 1'b1);
        check("t4_wait_depth", wait_depth, 3);
        end_dl("t4");
        check("t4_stable", stab_err, 0);

        // randomized bursts around the top of the address space
        for (int p = 0; p < 3; p++) begin
            ack_lat = $urandom_range(1, 6);
            for (int i = 0; i < 40; i++) begin
                w = 23'h7FFFFE + 23'($urandom_range(0, 3));
                send_byte({1'($urandom), w, 1'($urandom)}, 8'($urandom), t);
                repeat ($urandom_range(0, 3)) tick();
            end
            end_dl($sformatf("rnd%0d", p));
        end

        // reset with one request pending and two words queued
        hold_cycles = 100000;
        for (int i = 0; i < 6; i++) send_byte(25'h080 + 25'(i), 8'(8'hC0 + i), t);
        repeat (3) tick();
        n0 = tog_t.size();
        d0 = done_cnt;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_pend_busy", busy, 1'b1);
        check("rst_pend_wait", ioctl_wait, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        m_hv = 0;
        hold_cycles = 0;
        repeat (30) tick();
        check("rst_no_toggle", tog_t.size() - n0, 0);
        check("rst_busy_drop", busy, 1'b0);
        check("rst_no_done", done_cnt - d0, 0);
        compare_entries("rst");
        check("final_stable", stab_err, 0);
        check("final_done_busy", done_busy_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
